ksa_pipe_adder: RTL and testbench



---
 rtl/ksa_pipe_adder.sv | 136 +++++++++++++
 tb/tb_ksa_pipe_adder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and a global stall.
// Optional signed saturation on overflow when KSA_SAT_EN is defined.
module ksa_pipe_adder #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned LVL_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int LPS   = int'(LVL_PER_STG);
  localparam int NSTG  = (LOG2W + LPS - 1) / LPS;

  logic             w_adv;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;

  // Index 0 is the operand-capture stage; 1..NSTG are prefix stages.
  logic [WIDTH-1:0] r_g    [NSTG+1];
  logic [WIDTH-1:0] r_p    [NSTG+1];
  logic [WIDTH-1:0] r_pb   [NSTG+1];
  logic             r_c0   [NSTG+1];
  logic             r_amsb [NSTG+1];
  logic             r_vld  [NSTG+1];

  logic [WIDTH-1:0] w_g [NSTG+1];
  logic [WIDTH-1:0] w_p [NSTG+1];

  logic [WIDTH-1:0] w_cin_vec;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;

  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  assign w_adv    = !r_out_vld || out_ready;
  assign in_ready = w_adv;
  assign w_beff   = in_sub ? ~in_b : in_b;
  assign w_c0     = in_sub | in_cin;

  always_comb begin
    logic [WIDTH-1:0] t_g, t_p;
    t_g = '0;
    t_p = '0;
    w_g = '{default: '0};
    w_p = '{default: '0};
    for (int s = 1; s <= NSTG; s++) begin
      t_g = r_g[s-1];
      t_p = r_p[s-1];
      // c0 enters as the generate of bit -1, so every group G ends up as the true carry.
      if (s == 1) t_g[0] = t_g[0] | (t_p[0] & r_c0[0]);
      for (int l = (s - 1) * LPS; l < s * LPS && l < LOG2W; l++) begin
        t_g = t_g | (t_p & (t_g << (1 << l)));
        t_p = t_p & ((t_p << (1 << l)) | ~({WIDTH{1'b1}} << (1 << l)));
      end
      w_g[s] = t_g;
      w_p[s] = t_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= NSTG; s++) begin
        r_vld[s]  <= 1'b0;
        r_g[s]    <= '0;
        r_p[s]    <= '0;
        r_pb[s]   <= '0;
        r_c0[s]   <= 1'b0;
        r_amsb[s] <= 1'b0;
      end
    end else if (w_adv) begin
      r_vld[0]  <= in_valid;
      r_g[0]    <= in_a & w_beff;
      r_p[0]    <= in_a ^ w_beff;
      r_pb[0]   <= in_a ^ w_beff;
      r_c0[0]   <= w_c0;
      r_amsb[0] <= in_a[WIDTH-1];
      for (int s = 1; s <= NSTG; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_g[s]    <= w_g[s];
        r_p[s]    <= w_p[s];
        r_pb[s]   <= r_pb[s-1];
        r_c0[s]   <= r_c0[s-1];
        r_amsb[s] <= r_amsb[s-1];
      end
    end
  end

  assign w_cin_vec = {r_g[NSTG][WIDTH-2:0], r_c0[NSTG]};
  assign w_cout    = r_g[NSTG][WIDTH-1];
  assign w_ovf     = r_g[NSTG][WIDTH-1] ^ r_g[NSTG][WIDTH-2];

  always_comb begin
    w_res = r_pb[NSTG] ^ w_cin_vec;
`ifdef KSA_SAT_EN
    if (w_ovf) w_res = r_amsb[NSTG] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    w_res = r_pb[NSTG] ^ w_cin_vec;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_adv) begin
      r_out_vld <= r_vld[NSTG];
      r_sum     <= w_res;
      r_cout    <= w_cout;
      r_ovf     <= w_ovf;
    end
  end

  assign out_valid = r_out_vld;
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Bench for ksa_pipe_adder: four parameterisations checked against an arithmetic reference model.
// Honours KSA_SAT_EN in its expectations.
module tb_ksa_pipe_adder;

  localparam int ND = 4;
  localparam int DW  [ND] = '{16, 13, 32, 32};
  localparam int LAT [ND] = '{4, 6, 7, 4};

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] a_i    [ND];
  logic [31:0] b_i    [ND];
  logic        v_i    [ND];
  logic        cin_i  [ND];
  logic        sub_i  [ND];
  logic        ordy_i [ND];
  logic        irdy   [ND];
  logic        ov     [ND];
  logic        co     [ND];
  logic        of     [ND];
  logic [31:0] sum_o  [ND];
  logic [15:0] s0;
  logic [12:0] s1;
  logic [31:0] s2, s3;

  exp_t        sbq [ND][$];
  logic        seen [ND];
  logic        stall_prev [ND];
  logic        acc_fl [ND];
  logic [31:0] held_sum [ND];
  logic        held_co [ND];
  logic        held_of [ND];
  logic        lat_chk;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n;

  ksa_pipe_adder #(.WIDTH(16), .LVL_PER_STG(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_i[0]), .in_ready(irdy[0]), .in_a(a_i[0][15:0]),
    .in_b(b_i[0][15:0]), .in_cin(cin_i[0]), .in_sub(sub_i[0]), .out_valid(ov[0]),
    .out_ready(ordy_i[0]), .out_sum(s0), .out_cout(co[0]), .out_ovf(of[0]));
  ksa_pipe_adder #(.WIDTH(13), .LVL_PER_STG(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_i[1]), .in_ready(irdy[1]), .in_a(a_i[1][12:0]),
    .in_b(b_i[1][12:0]), .in_cin(cin_i[1]), .in_sub(sub_i[1]), .out_valid(ov[1]),
    .out_ready(ordy_i[1]), .out_sum(s1), .out_cout(co[1]), .out_ovf(of[1]));
  ksa_pipe_adder #(.WIDTH(32), .LVL_PER_STG(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_i[2]), .in_ready(irdy[2]), .in_a(a_i[2]),
    .in_b(b_i[2]), .in_cin(cin_i[2]), .in_sub(sub_i[2]), .out_valid(ov[2]),
    .out_ready(ordy_i[2]), .out_sum(s2), .out_cout(co[2]), .out_ovf(of[2]));
  ksa_pipe_adder #(.WIDTH(32), .LVL_PER_STG(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v_i[3]), .in_ready(irdy[3]), .in_a(a_i[3]),
    .in_b(b_i[3]), .in_cin(cin_i[3]), .in_sub(sub_i[3]), .out_valid(ov[3]),
    .out_ready(ordy_i[3]), .out_sum(s3), .out_cout(co[3]), .out_ovf(of[3]));

  assign sum_o[0] = {16'b0, s0};
  assign sum_o[1] = {19'b0, s1};
  assign sum_o[2] = s2;
  assign sum_o[3] = s3;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the masked operands.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    exp_t e;
    longint mask, half, ua, ub, c0, full, sa, sb, ss;
    logic [31:0] beff;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    beff = sub ? ~b : b;
    ua   = longint'(a) & mask;
    ub   = longint'(beff) & mask;
    c0   = (sub || cin) ? 1 : 0;
    full = ua + ub + c0;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    ss   = sa + sb + c0;
    e.ovf  = (ss >= half) || (ss < -half);
    e.sum  = 32'(full & mask);
    e.cout = ((full >> w) & 1) != 0;
`ifdef KSA_SAT_EN
    if (e.ovf) e.sum = 32'((ua >= half) ? half : half - 1);
`endif
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut%0d observed %0h expected %0h", tag, k, obs, expv);
    end
  endtask

  // Samples every DUT at the falling edge, then advances to just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      chk("in_ready", k, irdy[k], !(ov[k] && !ordy_i[k]));
      if (stall_prev[k]) begin
        chk("hold_sum", k, sum_o[k], held_sum[k]);
        chk("hold_cout", k, co[k], held_co[k]);
        chk("hold_ovf", k, of[k], held_of[k]);
      end
      if (ov[k]) begin
        chk("unexpected_beat", k, sbq[k].size() > 0, 1);
        if (sbq[k].size() > 0) begin
          e = sbq[k][0];
          if (!seen[k] && lat_chk) chk("latency", k, cyc - e.acc + 1, LAT[k]);
          seen[k] = 1'b1;
          chk("sum", k, sum_o[k], e.sum);
          chk("cout", k, co[k], e.cout);
          chk("ovf", k, of[k], e.ovf);
          if (ordy_i[k]) begin
            void'(sbq[k].pop_front());
            seen[k] = 1'b0;
          end
        end
      end
      stall_prev[k] = ov[k] && !ordy_i[k];
      held_sum[k]   = sum_o[k];
      held_co[k]    = co[k];
      held_of[k]    = of[k];
      acc_fl[k]     = v_i[k] && irdy[k];
      if (acc_fl[k]) begin
        e = model(DW[k], a_i[k], b_i[k], cin_i[k], sub_i[k]);
        e.acc = cyc + 1;
        sbq[k].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic [15:0] es, input logic ec,
                          input logic eo, input string tag);
    a_i[0] = {16'b0, a};
    b_i[0] = {16'b0, b};
    cin_i[0] = cin;
    sub_i[0] = sub;
    ordy_i[0] = 1'b1;
    v_i[0] = 1'b1;
    tick();
    v_i[0] = 1'b0;
    for (int i = 0; i < 12 && !ov[0]; i++) tick();
    chk({tag, "_valid"}, 0, ov[0], 1);
    chk({tag, "_sum"}, 0, sum_o[0], {16'b0, es});
    chk({tag, "_cout"}, 0, co[0], ec);
    chk({tag, "_ovf"}, 0, of[0], eo);
    tick();
  endtask

  task automatic drain(input string tag);
    repeat (14) tick();
    for (int k = 0; k < ND; k++) chk(tag, k, sbq[k].size(), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    lat_chk = 1'b1;
    n = 0;
    for (int k = 0; k < ND; k++) begin
      a_i[k] = '0; b_i[k] = '0; v_i[k] = 1'b0; cin_i[k] = 1'b0; sub_i[k] = 1'b0;
      ordy_i[k] = 1'b1; seen[k] = 1'b0; stall_prev[k] = 1'b0; acc_fl[k] = 1'b0;
      held_sum[k] = '0; held_co[k] = 1'b0; held_of[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("rst_valid", k, ov[k], 0);
      chk("rst_sum", k, sum_o[k], 0);
      chk("rst_cout", k, co[k], 0);
      chk("rst_ovf", k, of[k], 0);
      chk("rst_ready", k, irdy[k], 1);
    end
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
`ifdef KSA_SAT_EN
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, "add_ovf");
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, "sub_ovf");
`else
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
`endif
    directed(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    drain("directed_empty");

    // Backpressure: 16 back-to-back beats with a random out_ready.
    lat_chk = 1'b0;
    v_i[0] = 1'b1;
    a_i[0] = $urandom(); b_i[0] = $urandom();
    cin_i[0] = 1'($urandom_range(0, 1)); sub_i[0] = 1'($urandom_range(0, 1));
    for (int it = 0; it < 400 && n < 16; it++) begin
      ordy_i[0] = 1'($urandom_range(0, 1));
      tick();
      if (acc_fl[0]) begin
        n++;
        a_i[0] = $urandom(); b_i[0] = $urandom();
        cin_i[0] = 1'($urandom_range(0, 1)); sub_i[0] = 1'($urandom_range(0, 1));
      end
    end
    v_i[0] = 1'b0;
    ordy_i[0] = 1'b1;
    chk("bp_beats_sent", 0, n, 16);
    drain("bp_empty");

    // Reset with three beats held in a stalled pipe.
    ordy_i[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_i[0] = $urandom(); b_i[0] = $urandom();
      v_i[0] = 1'b1;
      tick();
    end
    v_i[0] = 1'b0;
    repeat (3) tick();
    chk("pre_rst_valid", 0, ov[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 0, ov[0], 0);
    chk("rst_async_sum", 0, sum_o[0], 0);
    chk("rst_async_cout", 0, co[0], 0);
    chk("rst_async_ovf", 0, of[0], 0);
    for (int k = 0; k < ND; k++) begin
      sbq[k].delete();
      seen[k] = 1'b0;
      stall_prev[k] = 1'b0;
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    ordy_i[0] = 1'b1;
    lat_chk = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) tick();
    a_i[0] = $urandom(); b_i[0] = $urandom();
    v_i[0] = 1'b1;
    tick();
    v_i[0] = 1'b0;
    drain("post_rst_empty");

    // Random add/sub sweep across all parameterisations.
    for (int i = 0; i < 1000; i++) begin
      for (int k = 0; k < ND; k++) begin
        v_i[k] = 1'b1;
        a_i[k] = $urandom();
        b_i[k] = $urandom();
        cin_i[k] = 1'($urandom_range(0, 1));
        sub_i[k] = 1'($urandom_range(0, 1));
        ordy_i[k] = 1'b1;
      end
      tick();
    end
    for (int k = 0; k < ND; k++) v_i[k] = 1'b0;
    drain("sweep_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
